// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution: sequences the shared comparator, owns the BHT,
// and raises flush/redirect on a direction mispredict.
module branch_resolve_ctrl #(
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic [31:0]       br_pc,
   input  logic [2:0]        br_funct3,
   input  logic [31:0]       br_rs1,
   input  logic [31:0]       br_rs2,
   input  logic [31:0]       br_imm,
   input  logic              br_pred_taken,
   output logic [31:0]       cmp_a,
   output logic [31:0]       cmp_b,
   output logic [2:0]        cmp_funct3,
   input  logic              cmp_take,
   output logic              res_valid,
   output logic              res_taken,
   output logic              flush,
   output logic              redir_valid,
   output logic [31:0]       redir_pc,
   input  logic              redir_ack,
   input  logic [31:0]       bht_rd_pc,
   output logic              bht_rd_taken,
   output logic [CNT_W-1:0]  mispredict_cnt
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_EVAL  = 2'b01;
   localparam logic [1:0] S_REDIR = 2'b10;

   logic [1:0]       state;
   logic [31:0]      pc_q;
   logic [31:0]      imm_q;
   logic             pred_q;
   logic [1:0]       bht [BHT_ENTRIES];
   logic [IDX_W-1:0] idx_upd;
   logic [IDX_W-1:0] idx_rd;
   logic [1:0]       cur_cnt;
   logic [1:0]       nxt_cnt;
   logic [31:0]      target;
   logic             accept;
   logic             unused_pc;

   assign br_ready  = (state == S_IDLE);
   assign accept    = br_valid && br_ready;
   assign idx_upd   = pc_q[IDX_W+1:2];
   assign idx_rd    = bht_rd_pc[IDX_W+1:2];
   assign target    = pc_q + (cmp_take ? imm_q : 32'd4);
   assign unused_pc = ^{bht_rd_pc[31:IDX_W+2], bht_rd_pc[1:0]};

   // Reads the registered table, so a same-cycle update is not visible yet.
   assign bht_rd_taken = bht[idx_rd][1];
   assign cur_cnt      = bht[idx_upd];

   always_comb begin
      nxt_cnt = cur_cnt;
      if (cmp_take && cur_cnt != 2'b11)
         nxt_cnt = cur_cnt + 2'b01;
      else if (!cmp_take && cur_cnt != 2'b00)
         nxt_cnt = cur_cnt - 2'b01;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++)
            bht[i] <= 2'b01;
      end else if (state == S_EVAL) begin
         bht[idx_upd] <= nxt_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         pc_q           <= '0;
         imm_q          <= '0;
         pred_q         <= 1'b0;
         cmp_a          <= '0;
         cmp_b          <= '0;
         cmp_funct3     <= '0;
         res_valid      <= 1'b0;
         res_taken      <= 1'b0;
         flush          <= 1'b0;
         redir_valid    <= 1'b0;
         redir_pc       <= '0;
         mispredict_cnt <= '0;
      end else begin
         res_valid <= 1'b0;
         flush     <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  pc_q       <= br_pc;
                  imm_q      <= br_imm;
                  pred_q     <= br_pred_taken;
                  cmp_a      <= br_rs1;
                  cmp_b      <= br_rs2;
                  cmp_funct3 <= br_funct3;
                  state      <= S_EVAL;
               end
            end
            S_EVAL: begin
               res_valid <= 1'b1;
               res_taken <= cmp_take;
               if (cmp_take != pred_q) begin
                  flush       <= 1'b1;
                  redir_valid <= 1'b1;
                  redir_pc    <= target;
                  if (mispredict_cnt != '1)
                     mispredict_cnt <= mispredict_cnt + 1'b1;
                  state       <= S_REDIR;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_REDIR: begin
               if (redir_ack) begin
                  redir_valid <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
